// File: rtl/i2c_wr_sequencer_if.sv
// Request and register-bus bundle between the requesting logic, i2c_wr_sequencer and the I2C master top.
// master = sequencer view, slave = view of the environment (requester plus I2C master core).
interface i2c_wr_sequencer_if;
    logic       Req_valid;
    logic       Req_ready;
    logic [6:0] Req_dev;
    logic [7:0] Req_reg;
    logic [7:0] Req_data;
    logic       Busy;
    logic       Done;
    logic       Err_nack;
    logic       Err_al;
    logic       Err_to;
    logic [7:0] Addr;
    logic [7:0] DataOut;
    logic [7:0] DataIn;
    logic       Wr;
    logic       Int;

    modport master (
        input  Req_valid, Req_dev, Req_reg, Req_data, DataIn, Int,
        output Req_ready, Busy, Done, Err_nack, Err_al, Err_to, Addr, DataOut, Wr
    );

    modport slave (
        output Req_valid, Req_dev, Req_reg, Req_data, DataIn, Int,
        input  Req_ready, Busy, Done, Err_nack, Err_al, Err_to, Addr, DataOut, Wr
    );
endinterface

// File: rtl/i2c_wr_sequencer.sv
// Turns one {dev, reg, data} request into START/addr+W/reg/data/STOP on the I2C master register bus.
// Optional Int-wait timeout with master disable/re-enable: define I2C_WR_SEQUENCER_TIMEOUT_EN.
module i2c_wr_sequencer #(
    parameter logic [7:0]  PRESCALE = 8'd49,
    parameter logic [7:0]  ADDR_PRE = 8'h00,
    parameter logic [7:0]  ADDR_CTR = 8'h02,
    parameter logic [7:0]  ADDR_TXR = 8'h03,
    parameter logic [7:0]  ADDR_CR  = 8'h04,
    parameter logic [7:0]  ADDR_SR  = 8'h04
`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
    ,
    parameter logic [15:0] TIMEOUT  = 16'd50000
`endif
) (
    input  logic                Clk,
    input  logic                Rst,
    i2c_wr_sequencer_if.master  bus
);

    localparam logic [7:0] CMD_STA_WR = 8'h90;
    localparam logic [7:0] CMD_WR     = 8'h10;
    localparam logic [7:0] CMD_WR_STO = 8'h50;
    localparam logic [7:0] CMD_STO    = 8'h40;
    localparam logic [7:0] CMD_IACK   = 8'h01;
    localparam logic [7:0] CTR_EN     = 8'h80;
    localparam logic [1:0] IDX_LAST   = 2'd2;

    typedef enum logic [3:0] {
        S_INIT_PRE,
        S_INIT_CTR,
        S_IDLE,
        S_LD_TX,
        S_CMD,
        S_WAIT,
        S_IACK,
        S_STOP,
        S_WAIT_S,
        S_IACK_S,
        S_FIN
`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
        ,
        S_TO_DIS,
        S_TO_EN
`endif
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [6:0] dev_q, dev_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] data_q, data_d;
    logic       sr_rxack_q, sr_rxack_d;
    logic       sr_al_q, sr_al_d;
    logic       pend_nack_q, pend_nack_d;
    logic       pend_al_q, pend_al_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] dout_q, dout_d;
    logic       wr_q, wr_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_nack_q, err_nack_d;
    logic       err_al_q, err_al_d;
`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        pend_to_q, pend_to_d;
    logic        err_to_q, err_to_d;
`endif

    // Only RxACK and AL steer the sequence; the remaining status bits are informational.
    logic unused_status_s;
    assign unused_status_s = ^{bus.DataIn[6], bus.DataIn[4:0]};

    function automatic logic [7:0] tx_byte(input logic [1:0] idx, input logic [6:0] dev,
                                           input logic [7:0] reg_addr, input logic [7:0] data);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {dev, 1'b0};
            2'd1:    b = reg_addr;
            default: b = data;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = CMD_STA_WR;
            2'd1:    c = CMD_WR;
            default: c = CMD_WR_STO;
        endcase
        return c;
    endfunction

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dev_d       = dev_q;
        reg_addr_d  = reg_addr_q;
        data_d      = data_q;
        sr_rxack_d  = sr_rxack_q;
        sr_al_d     = sr_al_q;
        pend_nack_d = pend_nack_q;
        pend_al_d   = pend_al_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        wr_d        = 1'b0;
        ready_d     = ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_nack_d  = err_nack_q;
        err_al_d    = err_al_q;
`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
        cnt_d       = cnt_q;
        pend_to_d   = pend_to_q;
        err_to_d    = err_to_q;
`endif
        case (state_q)
            S_INIT_PRE: begin
                wr_d    = 1'b1;
                addr_d  = ADDR_PRE;
                dout_d  = PRESCALE;
                state_d = S_INIT_CTR;
            end
            S_INIT_CTR: begin
                wr_d    = 1'b1;
                addr_d  = ADDR_CTR;
                dout_d  = CTR_EN;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                // Acceptance uses the registered ready so the handshake matches what the requester saw.
                if (ready_q && bus.Req_valid) begin
                    dev_d       = bus.Req_dev;
                    reg_addr_d  = bus.Req_reg;
                    data_d      = bus.Req_data;
                    idx_d       = 2'd0;
                    ready_d     = 1'b0;
                    busy_d      = 1'b1;
                    err_nack_d  = 1'b0;
                    err_al_d    = 1'b0;
                    pend_nack_d = 1'b0;
                    pend_al_d   = 1'b0;
`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
                    err_to_d    = 1'b0;
                    pend_to_d   = 1'b0;
`endif
                    state_d     = S_LD_TX;
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_LD_TX: begin
                wr_d    = 1'b1;
                addr_d  = ADDR_TXR;
                dout_d  = tx_byte(idx_q, dev_q, reg_addr_q, data_q);
                state_d = S_CMD;
            end
            S_CMD: begin
                wr_d    = 1'b1;
                addr_d  = ADDR_CR;
                dout_d  = cmd_byte(idx_q);
`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
                cnt_d   = 16'd0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                addr_d = ADDR_SR;
                if (bus.Int) begin
                    sr_rxack_d = bus.DataIn[7];
                    sr_al_d    = bus.DataIn[5];
                    state_d    = S_IACK;
                end
`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
                else if (cnt_q >= TIMEOUT - 16'd1) begin
                    state_d = S_TO_DIS;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`else
                else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_IACK: begin
                wr_d   = 1'b1;
                addr_d = ADDR_CR;
                dout_d = CMD_IACK;
                if (sr_al_q) begin
                    pend_al_d = 1'b1;
                    state_d   = S_FIN;
                end else if (sr_rxack_q) begin
                    // The last byte's command already carried STO, so no separate STOP is needed.
                    if (idx_q != IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        pend_nack_d = 1'b1;
                        state_d     = S_FIN;
                    end
                end else if (idx_q != IDX_LAST) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_LD_TX;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_STOP: begin
                wr_d    = 1'b1;
                addr_d  = ADDR_CR;
                dout_d  = CMD_STO;
`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
                cnt_d   = 16'd0;
`endif
                state_d = S_WAIT_S;
            end
            S_WAIT_S: begin
                addr_d = ADDR_SR;
                if (bus.Int) begin
                    state_d = S_IACK_S;
                end
`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
                else if (cnt_q >= TIMEOUT - 16'd1) begin
                    state_d = S_TO_DIS;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`else
                else begin
                    state_d = S_WAIT_S;
                end
`endif
            end
            S_IACK_S: begin
                wr_d        = 1'b1;
                addr_d      = ADDR_CR;
                dout_d      = CMD_IACK;
                pend_nack_d = 1'b1;
                state_d     = S_FIN;
            end
            S_FIN: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                err_nack_d = pend_nack_q;
                err_al_d   = pend_al_q;
`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
                err_to_d   = pend_to_q;
`endif
                state_d    = S_IDLE;
            end
`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
            // A stuck bus is cleared by bouncing the master's enable.
            S_TO_DIS: begin
                wr_d    = 1'b1;
                addr_d  = ADDR_CTR;
                dout_d  = 8'h00;
                state_d = S_TO_EN;
            end
            S_TO_EN: begin
                wr_d      = 1'b1;
                addr_d    = ADDR_CTR;
                dout_d    = CTR_EN;
                pend_to_d = 1'b1;
                state_d   = S_FIN;
            end
`endif
            default: begin
                state_d = S_INIT_PRE;
            end
        endcase
    end

    // State, request/status capture and output registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= S_INIT_PRE;
            idx_q       <= 2'd0;
            dev_q       <= 7'd0;
            reg_addr_q  <= 8'd0;
            data_q      <= 8'd0;
            sr_rxack_q  <= 1'b0;
            sr_al_q     <= 1'b0;
            pend_nack_q <= 1'b0;
            pend_al_q   <= 1'b0;
            addr_q      <= 8'd0;
            dout_q      <= 8'd0;
            wr_q        <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_nack_q  <= 1'b0;
            err_al_q    <= 1'b0;
`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
            cnt_q       <= 16'd0;
            pend_to_q   <= 1'b0;
            err_to_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dev_q       <= dev_d;
            reg_addr_q  <= reg_addr_d;
            data_q      <= data_d;
            sr_rxack_q  <= sr_rxack_d;
            sr_al_q     <= sr_al_d;
            pend_nack_q <= pend_nack_d;
            pend_al_q   <= pend_al_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            wr_q        <= wr_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_nack_q  <= err_nack_d;
            err_al_q    <= err_al_d;
`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            pend_to_q   <= pend_to_d;
            err_to_q    <= err_to_d;
`endif
        end
    end

    assign bus.Addr      = addr_q;
    assign bus.DataOut   = dout_q;
    assign bus.Wr        = wr_q;
    assign bus.Req_ready = ready_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Err_nack  = err_nack_q;
    assign bus.Err_al    = err_al_q;
`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
    assign bus.Err_to    = err_to_q;
`else
    assign bus.Err_to    = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_wr_sequencer.sv
// Randomized bench for i2c_wr_sequencer: an I2C-master responder logs every register write and
// a transaction-level reference model predicts the write list and error flags from the request.
module tb_i2c_wr_sequencer;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    i2c_wr_sequencer_if bus ();

`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
    i2c_wr_sequencer #(.TIMEOUT(16'd100)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
`else
    i2c_wr_sequencer dut (.Clk(Clk), .Rst(Rst), .bus(bus));
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Per-byte slave outcome: 0 = ACK, 1 = NACK, 2 = arbitration lost.
    int          plan [3];
    int unsigned min_delay = 0;
    int unsigned max_delay = 3;
    bit          no_int    = 1'b0;

    logic [15:0] log_q [$];
    logic [15:0] exp_q [$];
    logic        exp_nack, exp_al, exp_to;

    int unsigned int_cnt = 0;
    int unsigned model_d;
    int          byte_i  = 0;
    logic [7:0]  pend_status = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] status_of(input int outcome);
        if (outcome == 1) return 8'h81;
        if (outcome == 2) return 8'h21;
        return 8'h01;
    endfunction

    // Responder: records writes and answers each byte/STOP command with Int after a random delay.
    always @(negedge Clk) begin
        if (Rst) begin
            bus.Int    = 1'b0;
            bus.DataIn = 8'h00;
            int_cnt    = 0;
            byte_i     = 0;
        end else begin
            if (int_cnt > 0) begin
                int_cnt--;
                if (int_cnt == 0) begin
                    bus.Int    = 1'b1;
                    bus.DataIn = pend_status;
                end
            end
            if (bus.Wr) begin
                log_q.push_back({bus.Addr, bus.DataOut});
                if (bus.Addr == 8'h04) begin
                    if (bus.DataOut == 8'h01) begin
                        bus.Int = 1'b0;
                    end else begin
                        if (bus.DataOut[7]) byte_i = 0;
                        else if (bus.DataOut[4] && byte_i < 2) byte_i++;
                        pend_status = bus.DataOut[4] ? status_of(plan[byte_i]) : 8'h01;
                        if (!no_int) begin
                            model_d = $urandom_range(max_delay, min_delay);
                            if (model_d == 0) begin
                                bus.Int    = 1'b1;
                                bus.DataIn = pend_status;
                            end else begin
                                int_cnt = model_d;
                            end
                        end
                    end
                end
            end
        end
    end

    // Transaction-level prediction of the register writes and the error reported at Done.
    task automatic build_expected(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] dt);
        logic [7:0] txb [3];
        logic [7:0] cmd [3];
        bit         ended;
        txb[0] = {dev, 1'b0}; txb[1] = rg;    txb[2] = dt;
        cmd[0] = 8'h90;       cmd[1] = 8'h10; cmd[2] = 8'h50;
        exp_q.delete();
        exp_nack = 1'b0; exp_al = 1'b0; exp_to = 1'b0;
        ended = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!ended) begin
                exp_q.push_back({8'h03, txb[i]});
                exp_q.push_back({8'h04, cmd[i]});
                if (no_int) begin
                    exp_q.push_back({8'h02, 8'h00});
                    exp_q.push_back({8'h02, 8'h80});
                    exp_to = 1'b1;
                    ended  = 1'b1;
                end else begin
                    exp_q.push_back({8'h04, 8'h01});
                    if (plan[i] == 2) begin
                        exp_al = 1'b1;
                        ended  = 1'b1;
                    end else if (plan[i] == 1) begin
                        if (i < 2) begin
                            exp_q.push_back({8'h04, 8'h40});
                            exp_q.push_back({8'h04, 8'h01});
                        end
                        exp_nack = 1'b1;
                        ended    = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic release_and_check_init();
        tick();
        Rst = 1'b0;
        log_q.delete();
        tick();
        check_eq("init_pre", {bus.Wr, bus.Addr, bus.DataOut}, {1'b1, 8'h00, 8'd49});
        check_eq("init_pre_rdy", bus.Req_ready, 1'b0);
        tick();
        check_eq("init_ctr", {bus.Wr, bus.Addr, bus.DataOut}, {1'b1, 8'h02, 8'h80});
        check_eq("init_ctr_rdy", bus.Req_ready, 1'b0);
        tick();
        check_eq("init_rdy", {bus.Req_ready, bus.Wr, bus.Busy}, {1'b1, 1'b0, 1'b0});
        check_eq("init_nwr", log_q.size(), 2);
    endtask

    task automatic start_req(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] dt);
        int n;
        bus.Req_valid = 1'b1;
        bus.Req_dev   = dev;
        bus.Req_reg   = rg;
        bus.Req_data  = dt;
        n = 0;
        while (!bus.Req_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check_eq("ready_timeout", 0, 1);
        tick();
        check_eq("accept", {bus.Busy, bus.Req_ready, bus.Done}, {1'b1, 1'b0, 1'b0});
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.Done && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check_eq("done_timeout", 0, 1);
        check_eq("errs", {bus.Err_nack, bus.Err_al, bus.Err_to}, {exp_nack, exp_al, exp_to});
        check_eq("busy_at_done", bus.Busy, 1'b0);
        check_eq("nwrites", log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("wr%0d", i), log_q[i], exp_q[i]);
    endtask

    task automatic run_txn(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] dt);
        build_expected(dev, rg, dt);
        log_q.delete();
        start_req(dev, rg, dt);
        bus.Req_valid = 1'b0;
        wait_done();
        tick();
        check_eq("done_pulse", bus.Done, 1'b0);
        check_eq("err_hold", {bus.Err_nack, bus.Err_al, bus.Err_to}, {exp_nack, exp_al, exp_to});
    endtask

    initial begin
        int extra_done;
        int n;
        logic [6:0] rd;
        logic [7:0] rr, rv;
        bus.Req_valid = 1'b0;
        bus.Req_dev   = 7'd0;
        bus.Req_reg   = 8'd0;
        bus.Req_data  = 8'd0;
        plan = '{0, 0, 0};
        repeat (3) tick();
        check_eq("rst_outs", {bus.Wr, bus.Addr, bus.DataOut, bus.Req_ready, bus.Busy, bus.Done,
                              bus.Err_nack, bus.Err_al, bus.Err_to}, 24'd0);
        release_and_check_init();

        plan = '{0, 0, 0};
        run_txn(7'h50, 8'h12, 8'hA5);
        plan = '{0, 1, 0};
        run_txn(7'h50, 8'h12, 8'hA5);
        plan = '{2, 0, 0};
        run_txn(7'h3C, 8'h01, 8'h7E);
        plan = '{0, 0, 1};
        run_txn(7'h7F, 8'hFF, 8'h00);

        // Held Req_valid with changed fields must not disturb the accepted transaction.
        plan = '{0, 0, 0};
        build_expected(7'h11, 8'h22, 8'h33);
        log_q.delete();
        start_req(7'h11, 8'h22, 8'h33);
        bus.Req_dev = 7'h44; bus.Req_reg = 8'h55; bus.Req_data = 8'h66;
        wait_done();
        build_expected(7'h44, 8'h55, 8'h66);
        log_q.delete();
        extra_done = 0;
        n = 0;
        tick();
        while (!bus.Req_ready && n < 200) begin
            if (bus.Done) extra_done++;
            check_eq("held_idle", bus.Busy, 1'b0);
            tick();
            n++;
        end
        check_eq("extra_done", extra_done, 0);
        tick();
        check_eq("accept2", bus.Busy, 1'b1);
        bus.Req_valid = 1'b0;
        wait_done();

        for (int k = 0; k < 16; k++) begin
            rd = 7'($urandom); rr = 8'($urandom); rv = 8'($urandom);
            plan = '{0, 0, 0};
            if ($urandom_range(3, 0) != 0) plan[$urandom_range(2, 0)] = int'($urandom_range(2, 1));
            run_txn(rd, rr, rv);
        end

        // Async reset while waiting for byte 1: immediate abort, no STOP, INIT again.
        plan = '{0, 0, 0};
        min_delay = 20; max_delay = 20;
        log_q.delete();
        start_req(7'h50, 8'h12, 8'hA5);
        bus.Req_valid = 1'b0;
        n = 0;
        while (log_q.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        check_eq("rst_point", log_q.size(), 5);
        Rst = 1'b1;
        #1;
        check_eq("async_rst", {bus.Wr, bus.Addr, bus.DataOut, bus.Req_ready, bus.Busy, bus.Done,
                               bus.Err_nack, bus.Err_al, bus.Err_to}, 24'd0);
        tick();
        release_and_check_init();
        min_delay = 0; max_delay = 3;
        plan = '{0, 0, 0};
        run_txn(7'h2A, 8'h80, 8'h01);

`ifdef I2C_WR_SEQUENCER_TIMEOUT_EN
        no_int = 1'b1;
        run_txn(7'h50, 8'h12, 8'hA5);
        no_int = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
